string_tape_accumulator_wide: RTL and testbench

Parametrised successor to the single-byte string tape accumulator. Accepts up to LANES string bytes per cycle over a valid/ready stream and packs them into a word-wide string buffer in tape format: a 4-byte little-endian length header, then the bytes, then an optional NUL, padded to a word boundary. On completion it reports the header byte offset and length, which the tape writer places on the structural tape.

---
 rtl/string_tape_accumulator_wide_pkg.sv | 18 +
 rtl/string_tape_accumulator_wide_lane_byte_packer.sv | 62 ++++++
 rtl/string_tape_accumulator_wide.sv | 149 ++++++++++++++
 tb/tb_string_tape_accumulator_wide.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/string_tape_accumulator_wide_pkg.sv
// rtl/string_tape_accumulator_wide_pkg.sv - shared tape types, header size and FSM state enum
package string_tape_accumulator_wide_pkg;

  typedef logic [31:0] TapeIndex;
  typedef logic [7:0]  UTF8_Char;
  typedef logic [31:0] buf_offset_t;

  localparam int STRING_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BODY,
    ST_FLUSH,
    ST_PATCH,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/string_tape_accumulator_wide_lane_byte_packer.sv
// rtl/string_tape_accumulator_wide_lane_byte_packer.sv - compacts variable-count byte beats into full words
module string_tape_accumulator_wide_lane_byte_packer
  import string_tape_accumulator_wide_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_i,
  input  logic                      push_i,
  input  logic [LANES*8-1:0]        bytes_i,
  input  logic [$clog2(LANES):0]    count_i,
  output logic                      word_full_o,
  output logic [LANES*8-1:0]        word_o,
  output logic [LANES*8-1:0]        res_data_o,
  output logic [$clog2(LANES)-1:0]  res_cnt_o
);

  localparam int W       = LANES * 8;
  localparam int RW      = $clog2(LANES);
  localparam int HDR_RES = STRING_HDR_BYTES % LANES;

  logic [W-1:0]   res_q, res_d, in_masked;
  logic [RW-1:0]  cnt_q, cnt_d;
  logic [RW:0]    total;
  logic [2*W-1:0] merged;

  // Residual bytes above cnt_q are kept zero, so the residual doubles as NUL + padding.
  always_comb begin
    in_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      in_masked[i*8 +: 8] = (i < int'(count_i)) ? bytes_i[i*8 +: 8] : 8'h00;
    end
    merged      = ({{W{1'b0}}, in_masked} << {cnt_q, 3'b000}) | {{W{1'b0}}, res_q};
    total       = {1'b0, cnt_q} + count_i;
    word_full_o = total[RW];
    word_o      = merged[W-1:0];
    res_d       = res_q;
    cnt_d       = cnt_q;
    if (init_i) begin
      res_d = '0;
      cnt_d = RW'(HDR_RES);
    end else if (push_i) begin
      res_d = total[RW] ? merged[2*W-1:W] : merged[W-1:0];
      cnt_d = total[RW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      cnt_q <= RW'(HDR_RES);
    end else begin
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  assign res_data_o = res_q;
  assign res_cnt_o  = cnt_q;

endmodule

// File: rtl/string_tape_accumulator_wide.sv
// rtl/string_tape_accumulator_wide.sv - packs string beats into the tape buffer with a length header
// STRING_TAPE_NUL_TERM_EN appends one NUL byte after every string.
module string_tape_accumulator_wide
  import string_tape_accumulator_wide_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int BUF_ADDR_W = 12
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*8-1:0]                  in_bytes,
  input  logic [$clog2(LANES+1)-1:0]          in_count,
  input  logic                                in_last,
  output logic                                mem_we,
  output logic [BUF_ADDR_W-$clog2(LANES)-1:0] mem_addr,
  output logic [LANES*8-1:0]                  mem_wdata,
  output logic [LANES-1:0]                    mem_be,
  output logic                                str_done,
  output logic [BUF_ADDR_W-1:0]               str_offset,
  output logic [BUF_ADDR_W:0]                 str_len,
  output logic                                err_overflow
);

  localparam int LB        = $clog2(LANES);
  localparam int WA        = BUF_ADDR_W - LB;
  localparam int CW        = $clog2(LANES + 1);
  localparam int HDR_WORDS = STRING_HDR_BYTES / LANES;
`ifdef STRING_TAPE_NUL_TERM_EN
  localparam bit NUL_EN = 1'b1;
`else
  localparam bit NUL_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [WA:0]         start_q, start_d, cur_q, cur_d;
  logic [BUF_ADDR_W:0] len_q, len_d;
  logic                err_q, err_d;
  logic [CW-1:0]       count_clamped;
  logic                pk_init, pk_push, pk_full;
  logic [LANES*8-1:0]  pk_word, pk_res_data;
  logic [LB-1:0]       pk_res_cnt;

  assign count_clamped = (in_count > CW'(LANES)) ? CW'(LANES) : in_count;

  string_tape_accumulator_wide_lane_byte_packer #(.LANES(LANES)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .init_i      (pk_init),
    .push_i      (pk_push),
    .bytes_i     (in_bytes),
    .count_i     (count_clamped),
    .word_full_o (pk_full),
    .word_o      (pk_word),
    .res_data_o  (pk_res_data),
    .res_cnt_o   (pk_res_cnt)
  );

  // Word pointers carry one extra bit: a set MSB means the buffer end has been reached.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    cur_d      = cur_q;
    len_d      = len_q;
    err_d      = err_q;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    str_done   = 1'b0;
    str_offset = '0;
    str_len    = '0;
    pk_init    = 1'b0;
    pk_push    = 1'b0;
    case (state_q)
      ST_IDLE, ST_BODY: begin
        in_ready = rst;
        if (in_valid && rst) begin
          if ((state_q == ST_IDLE && start_q[WA]) || (pk_full && cur_q[WA])) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            pk_push = 1'b1;
            len_d   = ((state_q == ST_IDLE) ? '0 : len_q) + (BUF_ADDR_W+1)'(count_clamped);
            if (pk_full) begin
              mem_we    = 1'b1;
              mem_addr  = cur_q[WA-1:0];
              mem_wdata = pk_word;
              mem_be    = '1;
              cur_d     = cur_q + (WA+1)'(1);
            end
            state_d = in_last ? ST_FLUSH : ST_BODY;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_PATCH;
        if (NUL_EN || pk_res_cnt != '0) begin
          if (cur_q[WA]) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_addr  = cur_q[WA-1:0];
            mem_wdata = pk_res_data;
            mem_be    = '1;
            cur_d     = cur_q + (WA+1)'(1);
          end
        end
      end
      ST_PATCH: begin
        mem_we          = 1'b1;
        mem_addr        = start_q[WA-1:0];
        mem_wdata[31:0] = 32'(len_q);
        mem_be[3:0]     = 4'hF;
        str_done        = 1'b1;
        str_offset      = {start_q[WA-1:0], {LB{1'b0}}};
        str_len         = len_q;
        start_d         = cur_q;
        cur_d           = cur_q + (WA+1)'(HDR_WORDS);
        pk_init         = 1'b1;
        state_d         = ST_IDLE;
      end
      ST_ERROR: in_ready = rst;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      cur_q   <= (WA+1)'(HDR_WORDS);
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cur_q   <= cur_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign err_overflow = err_q;

endmodule

// File: tb/tb_string_tape_accumulator_wide.sv
// tb/tb_string_tape_accumulator_wide.sv - directed table-driven bench for string_tape_accumulator_wide
module tb_string_tape_accumulator_wide;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [31:0] in_bytes = '0;
  logic [2:0]  in_count = '0;
  logic        in_ready, mem_we, str_done, err_overflow;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [11:0] str_offset;
  logic [12:0] str_len;

  logic        o_valid = 1'b0, o_last = 1'b0;
  logic [31:0] o_bytes = '0;
  logic [2:0]  o_count = '0;
  logic        o_ready, o_we, o_done, o_err;
  logic [2:0]  o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_be;
  logic [4:0]  o_off;
  logic [5:0]  o_len;

  string_tape_accumulator_wide #(.LANES(4), .BUF_ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bytes(in_bytes),
    .in_count(in_count), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .str_done(str_done), .str_offset(str_offset),
    .str_len(str_len), .err_overflow(err_overflow)
  );

  string_tape_accumulator_wide #(.LANES(4), .BUF_ADDR_W(5)) dut_small (
    .clk(clk), .rst(rst), .in_valid(o_valid), .in_ready(o_ready), .in_bytes(o_bytes),
    .in_count(o_count), .in_last(o_last), .mem_we(o_we), .mem_addr(o_addr),
    .mem_wdata(o_wdata), .mem_be(o_be), .str_done(o_done), .str_offset(o_off),
    .str_len(o_len), .err_overflow(o_err)
  );

  typedef struct { logic [31:0] b; logic [2:0] c; logic l; int gap; } beat_t;
  typedef struct { logic [9:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
  typedef struct { logic [11:0] off; logic [12:0] len; } done_t;

  beat_t beats[$];
  wr_t   exp_wr[$], got_wr[$];
  done_t exp_done[$], got_done[$];
  int    n_vec = 0, n_bad = 0;
  int    o_wr_cnt = 0, o_done_cnt = 0, o_nrdy = 0;
  logic [2:0] o_max_addr = '0;

  always @(negedge clk) begin
    if (mem_we)   got_wr.push_back('{mem_addr, mem_wdata, mem_be});
    if (str_done) got_done.push_back('{str_offset, str_len});
    if (o_we) begin
      o_wr_cnt++;
      if (o_addr > o_max_addr) o_max_addr = o_addr;
    end
    if (o_done) o_done_cnt++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] b, input logic [2:0] c, input logic l);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_bytes = b;
    in_count = c;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL beat_accept: in_ready stuck low, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_commit();
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_no_done", str_done, 0);
    @(negedge clk);
    chk("patch_in_ready", in_ready, 0);
    chk("done_latency", str_done, 1);
  endtask

  task automatic compare_logs(input string tag);
    chk({tag, "_wr_count"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      chk($sformatf("%s_wr%0d_addr", tag, i), got_wr[i].a, exp_wr[i].a);
      chk($sformatf("%s_wr%0d_data", tag, i), got_wr[i].d, exp_wr[i].d);
      chk($sformatf("%s_wr%0d_be", tag, i), got_wr[i].be, exp_wr[i].be);
    end
    chk({tag, "_done_count"}, got_done.size(), exp_done.size());
    for (int i = 0; i < exp_done.size() && i < got_done.size(); i++) begin
      chk($sformatf("%s_done%0d_off", tag, i), got_done[i].off, exp_done[i].off);
      chk($sformatf("%s_done%0d_len", tag, i), got_done[i].len, exp_done[i].len);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Beats: garbage in unused upper lanes must be masked off.
    beats.push_back('{32'h6c707061, 3'd4, 1'b0, 0});
    beats.push_back('{32'hAABBCC65, 3'd1, 1'b1, 0});
    beats.push_back('{32'hEE656970, 3'd3, 1'b1, 0});
    beats.push_back('{32'h12345678, 3'd0, 1'b1, 0});
    beats.push_back('{32'hFF636261, 3'd3, 1'b0, 0});
    beats.push_back('{32'h99886564, 3'd2, 1'b0, 2});
    beats.push_back('{32'h77686766, 3'd3, 1'b1, 1});
    beats.push_back('{32'h7a797877, 3'd7, 1'b1, 0});

    exp_wr.push_back('{10'd1, 32'h6c707061, 4'hF});
    exp_wr.push_back('{10'd2, 32'h00000065, 4'hF});
    exp_wr.push_back('{10'd0, 32'h00000005, 4'hF});
    exp_wr.push_back('{10'd4, 32'h00656970, 4'hF});
    exp_wr.push_back('{10'd3, 32'h00000003, 4'hF});
    exp_done.push_back('{12'd0, 13'd5});
    exp_done.push_back('{12'd12, 13'd3});
    exp_done.push_back('{12'd20, 13'd0});
`ifdef STRING_TAPE_NUL_TERM_EN
    exp_wr.push_back('{10'd6, 32'h00000000, 4'hF});
    exp_wr.push_back('{10'd5, 32'h00000000, 4'hF});
    exp_wr.push_back('{10'd8, 32'h64636261, 4'hF});
    exp_wr.push_back('{10'd9, 32'h68676665, 4'hF});
    exp_wr.push_back('{10'd10, 32'h00000000, 4'hF});
    exp_wr.push_back('{10'd7, 32'h00000008, 4'hF});
    exp_wr.push_back('{10'd12, 32'h7a797877, 4'hF});
    exp_wr.push_back('{10'd13, 32'h00000000, 4'hF});
    exp_wr.push_back('{10'd11, 32'h00000004, 4'hF});
    exp_done.push_back('{12'd28, 13'd8});
    exp_done.push_back('{12'd44, 13'd4});
`else
    exp_wr.push_back('{10'd5, 32'h00000000, 4'hF});
    exp_wr.push_back('{10'd7, 32'h64636261, 4'hF});
    exp_wr.push_back('{10'd8, 32'h68676665, 4'hF});
    exp_wr.push_back('{10'd6, 32'h00000008, 4'hF});
    exp_wr.push_back('{10'd10, 32'h7a797877, 4'hF});
    exp_wr.push_back('{10'd9, 32'h00000004, 4'hF});
    exp_done.push_back('{12'd24, 13'd8});
    exp_done.push_back('{12'd36, 13'd4});
`endif

    // Reset holds every output low even with a beat offered.
    in_valid = 1'b1;
    in_bytes = 32'h6c707061;
    in_count = 3'd4;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_str_done", str_done, 0);
    chk("rst_err", err_overflow, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < beats.size(); i++) begin
      repeat (beats[i].gap) begin
        @(posedge clk);
        #1;
      end
      send_beat(beats[i].b, beats[i].c, beats[i].l);
      if (beats[i].l) check_commit();
    end
    repeat (2) @(posedge clk);
    #1;
    compare_logs("main");

    // Reset in the middle of a string discards it; next string restarts at offset 0.
    got_wr.delete();
    got_done.delete();
    send_beat(32'h6c707061, 3'd4, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("midrst_no_done", got_done.size(), 0);
    got_wr.delete();
    got_done.delete();
    exp_wr.delete();
    exp_done.delete();
    exp_wr.push_back('{10'd1, 32'h00656970, 4'hF});
    exp_wr.push_back('{10'd0, 32'h00000003, 4'hF});
    exp_done.push_back('{12'd0, 13'd3});
    send_beat(32'hEE656970, 3'd3, 1'b1);
    check_commit();
    repeat (2) @(posedge clk);
    #1;
    compare_logs("midrst");

    // 32-byte buffer, 40-byte string: words 1..7 fit, the eighth data word overflows.
    for (int k = 0; k < 10; k++) begin
      o_valid = 1'b1;
      o_bytes = 32'h41424344 + k;
      o_count = 3'd4;
      o_last  = (k == 9);
      @(negedge clk);
      if (!o_ready) o_nrdy++;
      @(posedge clk);
      #1;
    end
    o_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("ovf_err", o_err, 1);
    chk("ovf_wr_count", o_wr_cnt, 7);
    chk("ovf_max_addr", o_max_addr, 7);
    chk("ovf_no_done", o_done_cnt, 0);
    chk("ovf_ready_low_cycles", o_nrdy, 0);
    o_valid = 1'b1;
    o_count = 3'd4;
    o_last  = 1'b1;
    @(negedge clk);
    chk("ovf_err_in_ready", o_ready, 1);
    chk("ovf_err_no_we", o_we, 0);
    @(posedge clk);
    #1 o_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("ovf_after_wr_count", o_wr_cnt, 7);
    chk("ovf_after_no_done", o_done_cnt, 0);
    chk("ovf_err_sticky", o_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
